// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: stall/redirect controls, instruction-memory port and IF/ID outputs.
// FETCH_PERF_COUNT_EN adds the fetch/stall performance counter outputs.
interface instruction_fetch_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 20
);
    logic                   IF_ID_Hold;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_WIDTH-1:0]    pc_out;
    logic                   fetch_valid;
    logic                   halted;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0]            fetch_count;
    logic [15:0]            stall_count;
`endif

    // master is the fetch unit itself; slave is the pipeline/memory side.
    modport master (
        input  IF_ID_Hold, branch_taken, branch_target, imem_data,
`ifdef FETCH_PERF_COUNT_EN
        output fetch_count, stall_count,
`endif
        output imem_addr, instruction, pc_out, fetch_valid, halted
    );

    modport slave (
        output IF_ID_Hold, branch_taken, branch_target, imem_data,
`ifdef FETCH_PERF_COUNT_EN
        input  fetch_count, stall_count,
`endif
        input  imem_addr, instruction, pc_out, fetch_valid, halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC sequencing with stall, branch redirect and HALT detection.
// Optional macro FETCH_PERF_COUNT_EN adds saturating fetch/stall counters.
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 20,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input logic                    clock,
    input logic                    reset,
    instruction_fetch_unit_if.master bus
);
    typedef enum logic [2:0] {BOOT, FETCH, STALL, REDIRECT, HALTED} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic                   is_halt_word;

    assign is_halt_word = (bus.imem_data[INSTR_WIDTH-1 -: 4] == 4'hF);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            BOOT: state_d = FETCH;
            HALTED: begin
                instr_d = '0;
                valid_d = 1'b0;
            end
            // FETCH, STALL and REDIRECT share one rule set: branch beats hold beats fetch.
            default: begin
                if (bus.branch_taken) begin
                    pc_d    = bus.branch_target;
                    instr_d = '0;
                    valid_d = 1'b0;
                    state_d = REDIRECT;
                end else if (bus.IF_ID_Hold) begin
                    state_d = STALL;
                end else begin
                    instr_d  = bus.imem_data;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    if (is_halt_word) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instruction = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.fetch_valid = valid_q;
    assign bus.halted      = halted_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        fetch_upd;

    assign fetch_upd = (state_q == FETCH || state_q == STALL || state_q == REDIRECT) &&
                       !bus.branch_taken && !bus.IF_ID_Hold;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_upd && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
        if (state_q == STALL && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed and randomized steps
// compared each cycle against a behavioural fetch model.
module tb_instruction_fetch_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [19:0] mem [256];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(20)) bus ();

    instruction_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(20), .RESET_PC(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    // Behavioural model: after boot the unit is either running or halted.
    logic [7:0]  m_pc, m_pcout;
    logic [19:0] m_instr;
    logic        m_valid, m_halted, m_boot, m_in_stall;
    logic [15:0] m_fc, m_sc;

    task automatic model_reset();
        m_pc = 8'h00; m_pcout = 8'h00; m_instr = '0;
        m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
        m_in_stall = 1'b0; m_fc = '0; m_sc = '0;
    endtask

    task automatic model_edge(input logic h, input logic b, input logic [7:0] t);
        logic [19:0] w;
        if (m_in_stall && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        m_in_stall = 1'b0;
        if (m_halted) begin
            m_instr = '0; m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (b) begin
            m_pc = t; m_instr = '0; m_valid = 1'b0;
        end else if (h) begin
            m_in_stall = 1'b1;
        end else begin
            w = mem[m_pc];
            m_instr = w; m_pcout = m_pc; m_valid = 1'b1;
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            if (w[19:16] == 4'hF) m_halted = 1'b1;
            else m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"},   32'(bus.imem_addr),   32'(m_pc));
        chk({tag, ".instruction"}, 32'(bus.instruction), 32'(m_instr));
        chk({tag, ".pc_out"},      32'(bus.pc_out),      32'(m_pcout));
        chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(m_valid));
        chk({tag, ".halted"},      32'(bus.halted),      32'(m_halted));
`ifdef FETCH_PERF_COUNT_EN
        chk({tag, ".fetch_count"}, 32'(bus.fetch_count), 32'(m_fc));
        chk({tag, ".stall_count"}, 32'(bus.stall_count), 32'(m_sc));
`endif
    endtask

    task automatic step(input logic h, input logic b, input logic [7:0] t);
        bus.IF_ID_Hold = h; bus.branch_taken = b; bus.branch_target = t;
        @(posedge clock);
        model_edge(h, b, t);
        #1;
        check_all("step");
    endtask

    // Asserts reset mid-cycle and checks the outputs clear before any clock edge.
    task automatic do_reset();
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        reset = 1'b1;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 256; i++) mem[i] = 20'(i);
    endtask

    initial begin
        bus.IF_ID_Hold = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        fill_linear();
        model_reset();

        // Boot sequence and first fetches.
        reset = 1'b1;
        do_reset();
        step(0, 0, 0);
        chk("boot.valid", 32'(bus.fetch_valid), 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("boot.pc_out1", 32'(bus.pc_out), 32'd1);

        // Stall at PC=5.
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("stall.pc_out", 32'(bus.pc_out), 32'd4);
        chk("stall.imem_addr", 32'(bus.imem_addr), 32'd5);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("stall.held", 32'(bus.pc_out), 32'd4);
        step(0, 0, 0);
        chk("stall.release", 32'(bus.pc_out), 32'd5);

        // Branch during hold, then back-to-back branches and hold in redirect.
        step(1, 1, 8'h40);
        chk("br.imem_addr", 32'(bus.imem_addr), 32'h40);
        chk("br.valid", 32'(bus.fetch_valid), 32'd0);
        step(0, 0, 0);
        chk("br.pc_out", 32'(bus.pc_out), 32'h40);
        chk("br.valid1", 32'(bus.fetch_valid), 32'd1);
        step(0, 1, 8'h10); step(0, 1, 8'h20); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);

        // PC wrap.
        step(0, 1, 8'hFE);
        step(0, 0, 0); step(0, 0, 0);
        chk("wrap.ff", 32'(bus.pc_out), 32'hFF);
        step(0, 0, 0);
        chk("wrap.00", 32'(bus.pc_out), 32'h00);
        chk("wrap.valid", 32'(bus.fetch_valid), 32'd1);

        // Reset mid-stall; branch during BOOT ignored.
        step(1, 0, 0);
        do_reset();
        step(0, 1, 8'h33);
        step(0, 0, 0);
        chk("rst_stall.pc_out", 32'(bus.pc_out), 32'd0);

        // Reset mid-redirect discards the target.
        step(0, 1, 8'h80);
        do_reset();
        step(0, 0, 0); step(0, 0, 0);
        chk("rst_redir.pc_out", 32'(bus.pc_out), 32'd0);
        chk("rst_redir.imem_addr", 32'(bus.imem_addr), 32'd1);

        // HALT word at PC=7.
        mem[7] = 20'hF1234;
        do_reset();
        for (int i = 0; i < 9; i++) step(0, 0, 0);
        chk("halt.pc_out", 32'(bus.pc_out), 32'd7);
        chk("halt.instr", 32'(bus.instruction), 32'hF1234);
        step(1, 1, 8'h50);
        chk("halt.valid", 32'(bus.fetch_valid), 32'd0);
        chk("halt.halted", 32'(bus.halted), 32'd1);
        chk("halt.imem_addr", 32'(bus.imem_addr), 32'd7);
        step(0, 1, 8'h60); step(0, 0, 0);
        do_reset();
        chk("halt.rst", 32'(bus.halted), 32'd0);
        step(0, 0, 0); step(0, 0, 0);
        mem[7] = 20'h00007;

        // Randomized rounds with occasional HALT words.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = {($urandom_range(0, 63) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                          16'($urandom)};
            do_reset();
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3, 8'($urandom));
        end
        fill_linear();

`ifdef FETCH_PERF_COUNT_EN
        do_reset();
        step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        chk("perf.fetch10", 32'(bus.fetch_count), 32'd10);
        chk("perf.stall4", 32'(bus.stall_count), 32'd4);
        for (int i = 0; i < 70000; i++) step(0, 0, 0);
        chk("perf.sat", 32'(bus.fetch_count), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
